// File: rtl/cnn_acc_pkg.sv
// Shared types, default widths and the round/shift/saturate helper for the
// CNN convolution accumulator (optional ReLU selected by CNN_ACC_RELU_EN).
package cnn_acc_pkg;

   localparam int unsigned DEF_PROD_W = 23;
   localparam int unsigned DEF_ACC_W  = 32;
   localparam int unsigned DEF_OUT_W  = 14;
   localparam int unsigned DEF_KLEN   = 25;
   localparam int unsigned DEF_SHIFT  = 8;
   // Working width of sat_round; accumulators up to SAT_W-2 bits cannot overflow it
   localparam int unsigned SAT_W      = 64;

   typedef enum logic [1:0] {
      S_ACC,
      S_FIN,
      S_OUT
   } state_t;

   // val sits in the LSBs so a width cast of the whole struct yields the result
   typedef struct packed {
      logic                    ovf;
      logic signed [SAT_W-1:0] val;
   } sat_t;

   // Round half toward +inf, arithmetic shift, clamp to a signed out_w-bit range
   function automatic sat_t sat_round(input logic signed [SAT_W-1:0] acc,
                                      input int unsigned             shift,
                                      input int unsigned             out_w);
      logic signed [SAT_W-1:0] half;
      logic signed [SAT_W-1:0] r;
      logic signed [SAT_W-1:0] hi;
      logic signed [SAT_W-1:0] lo;
      sat_t                    o;
      half = SAT_W'(1) << (shift - 1);
      r    = (acc + half) >>> shift;
      hi   = (SAT_W'(1) << (out_w - 1)) - SAT_W'(1);
      lo   = ~hi;
      if (r > hi) begin
         o.val = hi;
         o.ovf = 1'b1;
      end else if (r < lo) begin
         o.val = lo;
         o.ovf = 1'b1;
      end else begin
         o.val = r;
         o.ovf = 1'b0;
      end
      return o;
   endfunction

endpackage

// File: rtl/cnn_acc_rnd_sat.sv
// Combinational round/saturate stage; CNN_ACC_RELU_EN clamps negatives to 0
// and restricts the overflow flag to upper-bound saturation.
module cnn_acc_rnd_sat
   import cnn_acc_pkg::*;
#(
   parameter int unsigned ACC_W = DEF_ACC_W,
   parameter int unsigned OUT_W = DEF_OUT_W,
   parameter int unsigned SHIFT = DEF_SHIFT
) (
   input  logic signed [ACC_W-1:0] acc,
   output logic signed [OUT_W-1:0] data_c,
   output logic                    ovf_c
);

   sat_t res_c;

   always_comb begin
      res_c  = sat_round(SAT_W'(acc), SHIFT, OUT_W);
      data_c = OUT_W'(res_c);
      ovf_c  = res_c.ovf;
`ifdef CNN_ACC_RELU_EN
      if (data_c[OUT_W-1]) begin
         data_c = '0;
         ovf_c  = 1'b0;
      end
`else
`endif
   end

endmodule

// File: rtl/cnn_conv_acc.sv
// Windowed product accumulator with bias, rounding, saturation and a
// valid/ready output; ReLU variant selected by CNN_ACC_RELU_EN.
module cnn_conv_acc
   import cnn_acc_pkg::*;
#(
   parameter int unsigned PROD_W = DEF_PROD_W,
   parameter int unsigned ACC_W  = DEF_ACC_W,
   parameter int unsigned OUT_W  = DEF_OUT_W,
   parameter int unsigned KLEN   = DEF_KLEN,
   parameter int unsigned SHIFT  = DEF_SHIFT
) (
   input  logic                     ap_clk,
   input  logic                     ap_rst,
   input  logic signed [PROD_W-1:0] in_prod,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [OUT_W-1:0]  bias,
   output logic signed [OUT_W-1:0]  out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     out_ovf
);

   localparam int unsigned TAP_W = (KLEN > 1) ? $clog2(KLEN) : 1;

   if ((ACC_W < PROD_W + $clog2(KLEN) + 1) || (ACC_W > SAT_W - 2) ||
       (SHIFT < 1) || (KLEN < 1)) begin : g_param_err
      $error("cnn_conv_acc: illegal ACC_W/SHIFT/KLEN combination");
   end

   state_t                  state_q;
   state_t                  state_d;
   logic [TAP_W-1:0]        tap_cnt;
   logic signed [ACC_W-1:0] acc;
   logic                    accept_c;
   logic                    last_tap_c;
   logic signed [OUT_W-1:0] rs_data_c;
   logic                    rs_ovf_c;

   cnn_acc_rnd_sat #(
      .ACC_W (ACC_W),
      .OUT_W (OUT_W),
      .SHIFT (SHIFT)
   ) u_rnd_sat (
      .acc    (acc),
      .data_c (rs_data_c),
      .ovf_c  (rs_ovf_c)
   );

   always_ff @(posedge ap_clk) begin
      if (ap_rst) state_q <= S_ACC;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      accept_c   = in_valid && in_ready;
      last_tap_c = (tap_cnt == TAP_W'(KLEN - 1));
      case (state_q)
         S_ACC:   if (accept_c && last_tap_c) state_d = S_FIN;
         S_FIN:   state_d = S_OUT;
         S_OUT:   if (out_ready) state_d = S_ACC;
         default: state_d = S_ACC;
      endcase
   end

   // in_ready is a registered decode of the next state, so it never sees out_ready combinationally
   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         in_ready  <= 1'b1;
         tap_cnt   <= '0;
         acc       <= '0;
         out_data  <= '0;
         out_ovf   <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         in_ready <= (state_d == S_ACC);
         if (state_q == S_ACC && accept_c) begin
            tap_cnt <= last_tap_c ? '0 : tap_cnt + TAP_W'(1);
            if (tap_cnt == '0) acc <= (ACC_W'(bias) <<< SHIFT) + ACC_W'(in_prod);
            else               acc <= acc + ACC_W'(in_prod);
         end
         if (state_q == S_FIN) begin
            out_data  <= rs_data_c;
            out_ovf   <= rs_ovf_c;
            out_valid <= 1'b1;
         end
         if (state_q == S_OUT && out_ready) out_valid <= 1'b0;
      end
   end

endmodule

// File: doc/cnn_conv_acc.md
# cnn_conv_acc

Accumulator stage directly downstream of the signed 9×14 product multiplier in the CNN convolution datapath. It consumes a stream of 23-bit signed products, sums `KLEN` of them onto a per-output bias, and rounds the sum back to the activation grid with a right shift. It then saturates the result to the 14-bit activation width and hands one activation per window to the next layer over a valid/ready handshake.

## Interface
Parameters:
- `PROD_W`, 23: signed product width from the multiplier.
- `ACC_W`, 32: accumulator width. Must satisfy `ACC_W >= PROD_W + clog2(KLEN) + 1`, so the accumulator never wraps.
- `OUT_W`, 14: signed activation width.
- `KLEN`, 25: products per output window (5×5 kernel). Must be ≥ 1.
- `SHIFT`, 8: fractional bits removed on output. Must be ≥ 1.

Ports (one synchronous clock; reset is synchronous and active-high):
- `ap_clk`  in  1  clock; all state updates on its rising edge.
- `ap_rst`  in  1  synchronous active-high reset.
- `in_prod`  in  PROD_W  signed product.
- `in_valid`  in  1  `in_prod` valid.
- `in_ready`  out  1  block accepts a product this cycle.
- `bias`  in  OUT_W  signed bias; sampled only on the first tap of a window.
- `out_data`  out  OUT_W  signed activation.
- `out_valid`  out  1  `out_data` valid.
- `out_ready`  in  1  consumer accepts `out_data`.
- `out_ovf`  out  1  saturation occurred for the current `out_data`.

## Operation
- A beat is accepted on a cycle where `in_valid && in_ready`.
- FSM states:
  - `S_ACC`: `in_ready=1`; each accepted beat increments `tap_cnt`.
    - On the first tap (`tap_cnt==0`): `acc <= sext(bias)<<SHIFT + sext(in_prod)`.
    - On later taps: `acc <= acc + sext(in_prod)`.
    - When the accepted beat is tap `KLEN-1`: go to `S_FIN` and clear `tap_cnt`.
  - `S_FIN`: `in_ready=0`.
    - Compute `r = (acc + (1<<(SHIFT-1))) >>> SHIFT`. This rounds half toward +∞.
    - Saturate `r` to [−2^(OUT_W−1), 2^(OUT_W−1)−1].
    - Register the result into `out_data` and the saturation flag into `out_ovf`.
    - Set `out_valid=1` and go to `S_OUT`.
  - `S_OUT`: `in_ready=0`. Hold `out_data`, `out_ovf` and `out_valid` stable until `out_ready`.
    - On `out_valid && out_ready`: clear `out_valid` and go to `S_ACC`.
- `in_prod` is ignored whenever `in_ready=0`. The upstream stage keeps its data held until it is accepted.
- Reset has priority over every event, including mid-window and while `out_valid` is held.
  - State returns to `S_ACC`; `tap_cnt`, `acc`, `out_data`, `out_ovf` and `out_valid` go to 0.
  - Any partial sum is discarded.
- There is no window overlap: the next window's first tap is accepted no earlier than the cycle after the output handshake.

## Timing
- Reset values: `in_ready=1` (from the first cycle after reset), `out_valid=0`, `out_data=0`, `out_ovf=0`.
- Latency: last tap accepted at edge N → `out_valid=1` after edge N+1.
- If `out_ready=1` is already high, the handshake completes at edge N+2 and the first tap of the next window can be accepted at edge N+3.
- Peak throughput: one output per `KLEN+2` cycles.
- `in_valid` gaps: `tap_cnt` and `acc` hold, with no timeout.
- `in_ready` is a pure function of the state (no combinational path from `out_ready`).

## Configuration
- `CNN_ACC_RELU_EN` defined:
  - After saturation, negative results are forced to 0.
  - `out_ovf` reflects only saturation at the upper bound.
- `CNN_ACC_RELU_EN` undefined: signed output passes through; `out_ovf` is set on either saturation bound.

## Structure
- Shared package `cnn_acc_pkg` holds:
  - the FSM state enum (`S_ACC`, `S_FIN`, `S_OUT`);
  - the default width constants;
  - a `sat_round` function (round, shift, saturate, overflow flag).
- One natural sub-module, `cnn_acc_rnd_sat`, a combinational round/saturate (plus optional ReLU) stage instantiated in `S_FIN`.
- Parameter-check assertion: `ACC_W` bound and `SHIFT>=1`.

## Test plan
- Bias 0, 25 products of 256, `out_ready=1`: `out_data=25`, `out_ovf=0`; `out_valid` rises 2 cycles after the last tap.
- Bias 100, 25 products of 0: `out_data=100`.
- Bias 0, products 4194303 ×25: `out_data=8191`, `out_ovf=1`.
- Bias 0, products −384 then 0 ×24:
  - without `CNN_ACC_RELU_EN`: `out_data=−1`, `out_ovf=0`;
  - with it: `out_data=0`, `out_ovf=0`.
- Full window, hold `out_ready=0` for 5 cycles with `in_valid=1`: `out_data` stays stable and `in_ready=0`; no product is consumed until the handshake, and the next window then starts cleanly.
- Feed 10 taps of 1000, pulse `ap_rst`, then 25 taps of 256 with bias 0: `out_data=25`, proving the partial sum was discarded.
